tag_interval_monitor: RTL

Parametrised multi-channel successor to the single-channel interval checker in the user sample shell. Takes the decoded tag stream from `si_tag_converter` and runs NUM_MON independent monitors. Each monitor measures the time between consecutive qualifying tags on a selected channel and edge, checks it against a programmable window, and keeps event and violation counters plus a first-failure capture. Control and status use a single-clock Wishbone slave; CDC to the bus domain is the instantiating shell's job.

---
 rtl/tag_monitor_pkg.sv | 37 +++
 rtl/interval_monitor_channel.sv | 146 ++++++++++++++
 rtl/tag_interval_monitor.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/tag_monitor_pkg.sv
// tag_monitor_pkg: shared types and constants for tag_interval_monitor.
//   edge_mode_e  - per-monitor edge qualification mode
//   mon_state_e  - per-monitor tracking state
//   ADR_* / OFF_* - global register addresses and per-monitor register offsets
//   *_RST        - reset values for the interval window and the ID register
package tag_monitor_pkg;

  typedef enum logic [1:0] {
    EM_RISE = 2'd0,
    EM_FALL = 2'd1,
    EM_BOTH = 2'd2,
    EM_RSVD = 2'd3   // behaves as EM_BOTH
  } edge_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } mon_state_e;

  // Global registers (full byte address, block 0)
  localparam logic [7:0] ADR_ID   = 8'h00;
  localparam logic [7:0] ADR_CTRL = 8'h04;
  localparam logic [7:0] ADR_NMON = 8'h08;

  // Per-monitor offsets within each 0x20 block
  localparam logic [4:0] OFF_CFG    = 5'h00;
  localparam logic [4:0] OFF_LOWER  = 5'h04;
  localparam logic [4:0] OFF_UPPER  = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_VIOL   = 5'h10;
  localparam logic [4:0] OFF_EVENT  = 5'h14;

  localparam logic [31:0] VERSION_ID = 32'h0000_0002;
  localparam logic [31:0] LOWER_RST  = 32'h0019_0000;
  localparam logic [31:0] UPPER_RST  = 32'h0020_0000;

endpackage

// File: rtl/interval_monitor_channel.sv
// interval_monitor_channel: one interval monitor.
//   Stage 1 (tag cycle): qualify tag, subtract prev_time, update prev_time.
//   Stage 2: saturate, window compare, counters, first-failure capture.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   enable_i..upper_i       live configuration from the register file
//   cfg_wr_i                config register written -> return to IDLE
//   soft_clr_i, freeze_i    global clear pulse / counter freeze
//   viol_wr_i, evt_wr_i     bus preload of the counters with cnt_wdata_i
//   valid_tag_i..tagtime_i  decoded tag stream
//   fail_valid_o..alarm_o   capture, counters and sticky alarm
module interval_monitor_channel import tag_monitor_pkg::*; #(
  parameter int TIME_WIDTH    = 64,
  parameter int DIFF_WIDTH    = 31,
  parameter int CNT_WIDTH     = 32,
  parameter int CHANNEL_WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [1:0]               mode_i,
  input  logic [CHANNEL_WIDTH-1:0] chan_sel_i,
  input  logic [DIFF_WIDTH-1:0]    lower_i,
  input  logic [DIFF_WIDTH-1:0]    upper_i,
  input  logic                     cfg_wr_i,
  input  logic                     soft_clr_i,
  input  logic                     freeze_i,
  input  logic                     viol_wr_i,
  input  logic                     evt_wr_i,
  input  logic [CNT_WIDTH-1:0]     cnt_wdata_i,
  input  logic                     valid_tag_i,
  input  logic [CHANNEL_WIDTH-1:0] channel_i,
  input  logic                     rising_edge_i,
  input  logic [TIME_WIDTH-1:0]    tagtime_i,
  output logic                     fail_valid_o,
  output logic [DIFF_WIDTH-1:0]    fail_diff_o,
  output logic [CNT_WIDTH-1:0]     viol_cnt_o,
  output logic [CNT_WIDTH-1:0]     event_cnt_o,
  output logic                     alarm_o
);

  mon_state_e              state_q, state_d;
  logic [TIME_WIDTH-1:0]   prev_q, prev_d;
  logic [TIME_WIDTH-1:0]   s1_diff_q, s1_diff_d;
  logic                    s1_vld_q, s1_vld_d;
  logic [CNT_WIDTH-1:0]    viol_q, viol_d, evt_q, evt_d;
  logic                    fv_q, fv_d;
  logic [DIFF_WIDTH-1:0]   fd_q, fd_d;

  // ---- stage 1 ----
  logic edge_ok, qual, to_idle;

  always_comb begin
    case (edge_mode_e'(mode_i))
      EM_RISE: edge_ok = rising_edge_i;
      EM_FALL: edge_ok = ~rising_edge_i;
      default: edge_ok = 1'b1;
    endcase
  end

  assign qual    = valid_tag_i & enable_i & (channel_i == chan_sel_i) & edge_ok;
  // A tag coinciding with any of these is dropped; the monitor re-arms later.
  assign to_idle = cfg_wr_i | ~enable_i | soft_clr_i;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    s1_diff_d = s1_diff_q;
    s1_vld_d  = 1'b0;
    if (to_idle) begin
      state_d = ST_IDLE;
    end else if (qual) begin
      prev_d  = tagtime_i;
      state_d = ST_ARMED;
      if (state_q == ST_ARMED) begin
        s1_vld_d  = 1'b1;
        s1_diff_d = tagtime_i - prev_q;
      end
    end
  end

  // ---- stage 2 ----
  logic [DIFF_WIDTH-1:0] dsat;
  logic                  viol, rec;

  assign dsat = (|s1_diff_q[TIME_WIDTH-1:DIFF_WIDTH]) ? '1 : s1_diff_q[DIFF_WIDTH-1:0];
  assign viol = (dsat < lower_i) | (dsat > upper_i);
  assign rec  = s1_vld_q & ~freeze_i;

  always_comb begin
    viol_d = viol_q;
    evt_d  = evt_q;
    fv_d   = fv_q;
    fd_d   = fd_q;
    if (soft_clr_i) begin
      // Clear beats anything landing in stage 2 this cycle.
      viol_d = '0;
      evt_d  = '0;
      fv_d   = 1'b0;
      fd_d   = '0;
    end else begin
      if (rec) begin
        if (evt_q != '1) evt_d = evt_q + CNT_WIDTH'(1);
        if (viol) begin
          if (viol_q != '1) viol_d = viol_q + CNT_WIDTH'(1);
          if (!fv_q) begin
            fv_d = 1'b1;
            fd_d = dsat;
          end
        end
      end
      if (viol_wr_i) viol_d = cnt_wdata_i;
      if (evt_wr_i)  evt_d  = cnt_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      s1_diff_q <= '0;
      s1_vld_q  <= 1'b0;
      viol_q    <= '0;
      evt_q     <= '0;
      fv_q      <= 1'b0;
      fd_q      <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      s1_diff_q <= s1_diff_d;
      s1_vld_q  <= s1_vld_d;
      viol_q    <= viol_d;
      evt_q     <= evt_d;
      fv_q      <= fv_d;
      fd_q      <= fd_d;
    end
  end

  assign fail_valid_o = fv_q;
  assign fail_diff_o  = fd_q;
  assign viol_cnt_o   = viol_q;
  assign event_cnt_o  = evt_q;
  // alarm is the first-failure flag itself; both clear together.
  assign alarm_o      = fv_q;

endmodule

// File: rtl/tag_interval_monitor.sv
// tag_interval_monitor: NUM_MON interval monitors on the decoded tag stream,
// with a single-clock Wishbone register file.
// Ports:
//   clk, rst                      clock, async active-high reset
//   valid_tag, channel,
//   rising_edge, tagtime          tag stream
//   wb_*                          Wishbone slave (ack 1 cycle after stb)
//   alarm                         sticky per-monitor failure flags
//   irq                           registered OR of irq-enabled alarms
module tag_interval_monitor import tag_monitor_pkg::*; #(
  parameter int NUM_MON       = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int DIFF_WIDTH    = 31,
  parameter int CNT_WIDTH     = 32,
  parameter int CHANNEL_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_tag,
  input  logic [CHANNEL_WIDTH-1:0] channel,
  input  logic                     rising_edge,
  input  logic [TIME_WIDTH-1:0]    tagtime,
  input  logic [7:0]               wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic                     wb_we_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic [NUM_MON-1:0]       alarm,
  output logic                     irq
);

  logic ack_q, freeze_q, irq_q;
  logic acc, wr, glob_sel, soft_clr;
  logic [4:0] off;

  assign acc      = wb_cyc_i & wb_stb_i;
  // Writes land at the end of the ack cycle.
  assign wr       = ack_q & acc & wb_we_i;
  assign glob_sel = (wb_adr_i[7:5] == 3'd0);
  assign off      = wb_adr_i[4:0];
  assign soft_clr = wr & (wb_adr_i == ADR_CTRL) & wb_dat_i[0];

  logic [NUM_MON-1:0]                    mon_sel, cfg_wr, viol_wr, evt_wr;
  logic [NUM_MON-1:0]                    en_q, irqen_q;
  logic [NUM_MON-1:0][1:0]               mode_q;
  logic [NUM_MON-1:0][CHANNEL_WIDTH-1:0] chan_q;
  logic [NUM_MON-1:0][DIFF_WIDTH-1:0]    lower_q, upper_q;
  logic [NUM_MON-1:0]                    fail_valid;
  logic [NUM_MON-1:0][DIFF_WIDTH-1:0]    fail_diff;
  logic [NUM_MON-1:0][CNT_WIDTH-1:0]     viol_cnt, event_cnt;

  always_comb begin
    mon_sel = '0;
    cfg_wr  = '0;
    viol_wr = '0;
    evt_wr  = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      mon_sel[i] = (wb_adr_i[7:5] == 3'(i + 1));
      cfg_wr[i]  = wr & mon_sel[i] & (off == OFF_CFG);
      viol_wr[i] = wr & mon_sel[i] & (off == OFF_VIOL);
      evt_wr[i]  = wr & mon_sel[i] & (off == OFF_EVENT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      freeze_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q <= acc & ~ack_q;
      if (wr && wb_adr_i == ADR_CTRL) freeze_q <= wb_dat_i[1];
      irq_q <= |(alarm & irqen_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= '0;
      irqen_q <= '0;
      mode_q  <= '0;
      chan_q  <= '0;
      for (int i = 0; i < NUM_MON; i++) begin
        lower_q[i] <= LOWER_RST[DIFF_WIDTH-1:0];
        upper_q[i] <= UPPER_RST[DIFF_WIDTH-1:0];
      end
    end else if (wr) begin
      for (int i = 0; i < NUM_MON; i++) begin
        if (mon_sel[i]) begin
          case (off)
            OFF_CFG: begin
              en_q[i]    <= wb_dat_i[0];
              mode_q[i]  <= wb_dat_i[2:1];
              irqen_q[i] <= wb_dat_i[3];
              chan_q[i]  <= wb_dat_i[CHANNEL_WIDTH+7:8];
            end
            OFF_LOWER: lower_q[i] <= wb_dat_i[DIFF_WIDTH-1:0];
            OFF_UPPER: upper_q[i] <= wb_dat_i[DIFF_WIDTH-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_MON; g++) begin : g_mon
    interval_monitor_channel #(
      .TIME_WIDTH   (TIME_WIDTH),
      .DIFF_WIDTH   (DIFF_WIDTH),
      .CNT_WIDTH    (CNT_WIDTH),
      .CHANNEL_WIDTH(CHANNEL_WIDTH)
    ) u_mon (
      .clk_i        (clk),
      .rst_i        (rst),
      .enable_i     (en_q[g]),
      .mode_i       (mode_q[g]),
      .chan_sel_i   (chan_q[g]),
      .lower_i      (lower_q[g]),
      .upper_i      (upper_q[g]),
      .cfg_wr_i     (cfg_wr[g]),
      .soft_clr_i   (soft_clr),
      .freeze_i     (freeze_q),
      .viol_wr_i    (viol_wr[g]),
      .evt_wr_i     (evt_wr[g]),
      .cnt_wdata_i  (wb_dat_i[CNT_WIDTH-1:0]),
      .valid_tag_i  (valid_tag),
      .channel_i    (channel),
      .rising_edge_i(rising_edge),
      .tagtime_i    (tagtime),
      .fail_valid_o (fail_valid[g]),
      .fail_diff_o  (fail_diff[g]),
      .viol_cnt_o   (viol_cnt[g]),
      .event_cnt_o  (event_cnt[g]),
      .alarm_o      (alarm[g])
    );
  end

  // Read decode; master holds the address through the ack cycle.
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    if (glob_sel) begin
      case (wb_adr_i)
        ADR_ID:   rdata = VERSION_ID;
        ADR_CTRL: rdata = {30'b0, freeze_q, 1'b0};
        ADR_NMON: rdata = 32'(NUM_MON);
        default:  ;
      endcase
    end
    for (int i = 0; i < NUM_MON; i++) begin
      if (mon_sel[i]) begin
        case (off)
          OFF_CFG: begin
            rdata[0]                 = en_q[i];
            rdata[2:1]               = mode_q[i];
            rdata[3]                 = irqen_q[i];
            rdata[CHANNEL_WIDTH+7:8] = chan_q[i];
          end
          OFF_LOWER:  rdata = 32'(lower_q[i]);
          OFF_UPPER:  rdata = 32'(upper_q[i]);
          OFF_STATUS: rdata = {fail_valid[i], 31'(fail_diff[i])};
          OFF_VIOL:   rdata = 32'(viol_cnt[i]);
          OFF_EVENT:  rdata = 32'(event_cnt[i]);
          default:    ;
        endcase
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = ack_q ? rdata : 32'h0;
  assign irq      = irq_q;

endmodule
